normalize_hs: RTL and testbench

Handshaked, multi-cycle successor to the combinational vector normalizer. It accepts a DIM-component signed fixed-point vector on a valid/ready input and computes the length with an iterative bit-serial square root. It then divides each component by the length using parallel bit-serial restoring dividers and presents the result on a valid/ready output. It sits between the ball-physics update stage and the collision-response stage, replacing the single-cycle divide and sqrt path to close timing.

---
 rtl/normalize_hs.sv | 211 +++++++++++++++++++++
 tb/tb_normalize_hs.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_hs.sv
// normalize_hs: handshaked fixed-point vector normalizer.
// Bit-serial restoring sqrt for the length, then DIM parallel restoring dividers.
module normalize_hs #(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 30,
    parameter int DIM        = 3,
    parameter int EPS        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] length,
    output logic [WIDTH-1:0] nx,
    output logic [WIDTH-1:0] ny,
    output logic [WIDTH-1:0] nz,
    output logic             close_to_0
);

    localparam int RW   = (WIDTH + FRAC_WIDTH + 1) / 2;
    localparam int D    = WIDTH - 1;
    localparam int HW   = FRAC_WIDTH + 1;
    localparam int DVW  = D + HW;
    localparam int SW   = 2 * WIDTH + 2;
    localparam int CMAX = (RW > D) ? RW : D;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SQR, ROOT, DIV, HOLD} state_t;

    state_t state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] cap [3];

    logic [2*RW-1:0]  rad;
    logic [RW+1:0]    rem;
    logic [RW-1:0]    root;
    logic [RW+3:0]    rem_sh, trial;
    logic [RW+1:0]    rem_nx;
    logic [RW-1:0]    root_nx;
    logic             sq_ge, close_nx;
    logic             root_last, div_last;

    logic [WIDTH-1:0] mag [3];
    logic [SW-1:0]    sum_full;
    logic [WIDTH-2:0] sum_sat;

    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] drem [3];
    logic [D-1:0]     dlo  [3];
    logic [D-1:0]     dq   [3];
    logic [2:0]       ovf;
    logic [DVW-1:0]   dvd  [3];
    logic [WIDTH:0]   dsh  [3];
    logic [2:0]       dge, ovf_ld;
    logic [WIDTH-1:0] drem_nx [3];
    logic [D-1:0]     dq_nx   [3];
    logic [D-1:0]     qf      [3];
    logic [WIDTH-1:0] nres    [3];

    function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] v);
        if (v == MINV) return MAXV;
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign in_ready  = (state == IDLE);
    assign root_last = (cnt == CW'(RW - 1));
    assign div_last  = (cnt == CW'(D - 1));

    // sum of squares, each term rescaled to the fixed-point grid
    always_comb begin
        sum_full = '0;
        for (int i = 0; i < 3; i++) begin
            mag[i]   = sat_abs(cap[i]);
            sum_full = sum_full
                     + ((SW'(mag[i]) * SW'(mag[i])) >> FRAC_WIDTH);
        end
        if (sum_full > SW'(MAXV))
            sum_sat = MAXV[WIDTH-2:0];
        else
            sum_sat = sum_full[WIDTH-2:0];
    end

    always_comb begin
        rem_sh   = {rem, rad[2*RW-1 -: 2]};
        trial    = (RW+4)'({root, 2'b01});
        sq_ge    = (rem_sh >= trial);
        rem_nx   = (RW+2)'(sq_ge ? rem_sh - trial : rem_sh);
        root_nx  = RW'({root, sq_ge});
        close_nx = (WIDTH'(root_nx) <= WIDTH'(EPS));
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dvd[i]     = DVW'(mag[i][D-1:0]) << FRAC_WIDTH;
            // quotient would not fit in D bits: clip instead of iterating
            ovf_ld[i]  = ((WIDTH+1)'(dvd[i][DVW-1 -: HW])
                          >= (WIDTH+1)'(root_nx));
            dsh[i]     = {drem[i], dlo[i][D-1]};
            dge[i]     = (dsh[i] >= {1'b0, dvs});
            drem_nx[i] = WIDTH'(dge[i] ? dsh[i] - {1'b0, dvs} : dsh[i]);
            dq_nx[i]   = D'({dq[i], dge[i]});
            qf[i]      = ovf[i] ? MAXV[D-1:0] : dq_nx[i];
            nres[i]    = cap[i][WIDTH-1] ? -{1'b0, qf[i]} : {1'b0, qf[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = SQR;
            SQR:  state_nx = ROOT;
            ROOT: if (root_last) state_nx = close_nx ? HOLD : DIV;
            DIV:  if (div_last) state_nx = HOLD;
            HOLD: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            rad        <= '0;
            rem        <= '0;
            root       <= '0;
            dvs        <= '0;
            ovf        <= '0;
            out_valid  <= 1'b0;
            length     <= '0;
            nx         <= '0;
            ny         <= '0;
            nz         <= '0;
            close_to_0 <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cap[i]  <= '0;
                drem[i] <= '0;
                dlo[i]  <= '0;
                dq[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cap[0] <= x;
                    cap[1] <= y;
                    cap[2] <= (DIM == 3) ? z : '0;
                end
                SQR: begin
                    rad  <= (2*RW)'(sum_sat) << FRAC_WIDTH;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                ROOT: begin
                    rad  <= rad << 2;
                    rem  <= rem_nx;
                    root <= root_nx;
                    cnt  <= cnt + 1'b1;
                    if (root_last) begin
                        cnt <= '0;
                        dvs <= WIDTH'(root_nx);
                        ovf <= ovf_ld;
                        for (int i = 0; i < 3; i++) begin
                            drem[i] <= ovf_ld[i] ? '0
                                     : WIDTH'(dvd[i][DVW-1 -: HW]);
                            dlo[i]  <= dvd[i][D-1:0];
                            dq[i]   <= '0;
                        end
                        if (close_nx) begin
                            length     <= WIDTH'(root_nx);
                            nx         <= cap[0];
                            ny         <= cap[1];
                            nz         <= cap[2];
                            close_to_0 <= 1'b1;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        drem[i] <= drem_nx[i];
                        dlo[i]  <= dlo[i] << 1;
                        dq[i]   <= dq_nx[i];
                    end
                    if (div_last) begin
                        length     <= dvs;
                        nx         <= nres[0];
                        ny         <= nres[1];
                        nz         <= nres[2];
                        close_to_0 <= 1'b0;
                        out_valid  <= 1'b1;
                    end
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_hs.sv
// tb_normalize_hs: directed and random checks of normalize_hs
// against an arithmetic reference model (DIM=3 and DIM=2 instances).
module tb_normalize_hs;

    localparam logic [31:0] ONE = 32'h40000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] x, y, z;
    logic [1:0]  iv, orr, ir, ov, cl;
    logic [1:0][31:0] len_o, nx_o, ny_o, nz_o;

    int n_cmp = 0;
    int n_bad = 0;

    normalize_hs #(.WIDTH(32), .FRAC_WIDTH(30), .DIM(3), .EPS(16)) u3 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .x(x), .y(y), .z(z),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .length(len_o[0]), .nx(nx_o[0]), .ny(ny_o[0]), .nz(nz_o[0]),
        .close_to_0(cl[0])
    );

    normalize_hs #(.WIDTH(32), .FRAC_WIDTH(30), .DIM(2), .EPS(16)) u2 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .x(x), .y(y), .z(z),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .length(len_o[1]), .nx(nx_o[1]), .ny(ny_o[1]), .nz(nz_o[1]),
        .close_to_0(cl[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input int tol);
        longint d;
        d = longint'($signed(obs)) - longint'($signed(exp));
        n_cmp++;
        assert (d >= -tol && d <= tol) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h +-%0d",
                   tag, obs, exp, tol);
        end
    endtask

    // length = floor(sqrt(sum * 2^30)), components = |c|*2^30/length
    function automatic void model(
        input logic [31:0] vx, vy, vz, input int dim,
        output logic [31:0] len, ex, ey, ez, output logic cls);
        logic [31:0] c [3];
        longint unsigned a, sum, v, lo, hi, mid, q;
        c[0] = vx; c[1] = vy; c[2] = (dim == 3) ? vz : 32'h0;
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            a = (c[i] == 32'h80000000) ? 64'h7FFFFFFF
              : longint'(($signed(c[i]) < 0) ? -$signed(c[i]) : $signed(c[i]));
            sum += (a * a) >> 30;
        end
        if (sum > 64'h7FFFFFFF) sum = 64'h7FFFFFFF;
        v = sum << 30;
        lo = 0; hi = 64'h80000000;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        len = lo[31:0];
        cls = (lo <= 16);
        if (cls) begin
            ex = c[0]; ey = c[1]; ez = c[2];
        end else begin
            for (int i = 0; i < 3; i++) begin
                a = (c[i] == 32'h80000000) ? 64'h7FFFFFFF
                  : longint'(($signed(c[i]) < 0) ? -$signed(c[i]) : $signed(c[i]));
                q = (a << 30) / lo;
                if (q > 64'h7FFFFFFF) q = 64'h7FFFFFFF;
                c[i] = c[i][31] ? -q[31:0] : q[31:0];
            end
            ex = c[0]; ey = c[1]; ez = c[2];
        end
    endfunction

    function automatic logic [31:0] rnd();
        int sh;
        sh = $urandom_range(0, 31);
        return 32'($signed($urandom) >>> sh);
    endfunction

    task automatic send(input int s, input logic [31:0] vx, vy, vz);
        int w;
        w = 0;
        while (!ir[s] && w < 200) begin
            @(posedge clk); #1; w++;
        end
        chk("send_ready", 32'(ir[s]), 1);
        x = vx; y = vy; z = vz;
        iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
    endtask

    task automatic wait_out(input int s, output int lat);
        lat = 0;
        while (!ov[s] && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        chk("out_valid_rise", 32'(ov[s]), 1);
    endtask

    task automatic check_res(input int s, input string tag,
                             input logic [31:0] vx, vy, vz);
        logic [31:0] el, ex, ey, ez;
        logic ec;
        model(vx, vy, vz, (s == 0) ? 3 : 2, el, ex, ey, ez, ec);
        chk({tag, "_len"}, len_o[s], el);
        chk({tag, "_nx"}, nx_o[s], ex);
        chk({tag, "_ny"}, ny_o[s], ey);
        chk({tag, "_nz"}, nz_o[s], ez);
        chk({tag, "_close"}, 32'(cl[s]), 32'(ec));
    endtask

    task automatic release_out(input int s);
        chk("hold_in_ready", 32'(ir[s]), 0);
        orr[s] = 1'b1;
        @(posedge clk); #1;
        orr[s] = 1'b0;
        chk("hs_out_valid", 32'(ov[s]), 0);
        chk("hs_in_ready", 32'(ir[s]), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen;
        logic [31:0] vx, vy, vz, el, ex, ey, ez;
        logic ec;

        x = '0; y = '0; z = '0;
        iv = '0; orr = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_out_valid", 32'(ov[s]), 0);
            chk("rst_len", len_o[s], 0);
            chk("rst_nx", nx_o[s], 0);
            chk("rst_nz", nz_o[s], 0);
            chk("rst_close", 32'(cl[s]), 0);
            chk("rst_in_ready", 32'(ir[s]), 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        send(0, ONE, 0, 0);
        wait_out(0, lat);
        chk("lat_unit", 32'(lat), 63);
        chk("unit_len", len_o[0], ONE);
        chk("unit_nx", nx_o[0], ONE);
        chk("unit_ny", ny_o[0], 0);
        check_res(0, "unit", ONE, 0, 0);
        release_out(0);

        send(0, 32'h26666666, 32'h33333333, 0);
        wait_out(0, lat);
        chk_tol("p68_len", len_o[0], ONE, 2);
        chk_tol("p68_nx", nx_o[0], 32'h26666666, 4);
        chk_tol("p68_ny", ny_o[0], 32'h33333333, 4);
        check_res(0, "p68", 32'h26666666, 32'h33333333, 0);
        release_out(0);

        send(0, 32'hE0000000, 0, 0);
        wait_out(0, lat);
        chk("neg_len", len_o[0], 32'h20000000);
        chk("neg_nx", nx_o[0], 32'hC0000000);
        check_res(0, "neg", 32'hE0000000, 0, 0);
        release_out(0);

        send(0, 0, 0, 0);
        wait_out(0, lat);
        chk("lat_zero", 32'(lat), 32);
        chk("zero_close", 32'(cl[0]), 1);
        chk("zero_len", len_o[0], 0);
        check_res(0, "zero", 0, 0, 0);
        release_out(0);

        send(0, 32'h60000000, 32'h60000000, 32'h60000000);
        wait_out(0, lat);
        chk_tol("sat_len", len_o[0], 32'h5A827999, 1);
        check_res(0, "sat", 32'h60000000, 32'h60000000, 32'h60000000);
        release_out(0);

        // backpressure: outputs frozen, new inputs ignored
        vx = 32'h26666666; vy = 32'hCCCCCCCD; vz = 32'h01000000;
        send(0, vx, vy, vz);
        wait_out(0, lat);
        model(vx, vy, vz, 3, el, ex, ey, ez, ec);
        for (int i = 0; i < 10; i++) begin
            iv[0] = i[0];
            x = $urandom; y = $urandom; z = $urandom;
            @(posedge clk); #1;
            chk("bp_len", len_o[0], el);
            chk("bp_nx", nx_o[0], ex);
            chk("bp_ny", ny_o[0], ey);
            chk("bp_nz", nz_o[0], ez);
            chk("bp_valid", 32'(ov[0]), 1);
            chk("bp_in_ready", 32'(ir[0]), 0);
        end
        iv[0] = 1'b1;
        x = ONE; y = 0; z = 0;
        orr[0] = 1'b1;
        @(posedge clk); #1;
        orr[0] = 1'b0;
        chk("bp_hs_valid", 32'(ov[0]), 0);
        chk("bp_hs_ready", 32'(ir[0]), 1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("bp_next_accept", 32'(ir[0]), 0);
        wait_out(0, lat);
        chk("lat_after_hs", 32'(lat), 63);
        check_res(0, "after_hs", ONE, 0, 0);
        release_out(0);

        // reset in the middle of ROOT
        send(0, 32'h26666666, 32'h33333333, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov[0]), 0);
        chk("mid_rst_len", len_o[0], 0);
        chk("mid_rst_nx", nx_o[0], 0);
        chk("mid_rst_close", 32'(cl[0]), 0);
        chk("mid_rst_ready", 32'(ir[0]), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        chk("mid_rst_no_out", 32'(seen), 0);
        send(0, ONE, 0, 0);
        wait_out(0, lat);
        chk("lat_post_rst", 32'(lat), 63);
        check_res(0, "post_rst", ONE, 0, 0);
        release_out(0);

        // DIM=2: z must be ignored
        send(1, ONE, 0, 32'h7FFFFFFF);
        wait_out(1, lat);
        chk("d2_lat", 32'(lat), 63);
        chk("d2_len", len_o[1], ONE);
        chk("d2_nx", nx_o[1], ONE);
        chk("d2_nz", nz_o[1], 0);
        check_res(1, "d2", ONE, 0, 32'h7FFFFFFF);
        release_out(1);

        for (int n = 0; n < 32; n++) begin
            int s;
            s = (n < 24) ? 0 : 1;
            vx = rnd(); vy = rnd(); vz = rnd();
            model(vx, vy, vz, (s == 0) ? 3 : 2, el, ex, ey, ez, ec);
            send(s, vx, vy, vz);
            wait_out(s, lat);
            chk("rnd_lat", 32'(lat), ec ? 32 : 63);
            check_res(s, "rnd", vx, vy, vz);
            release_out(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
